// File: rtl/float_pkg.sv
// Shared single-precision float constants, operand classes and classifier.
package float_pkg;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] FP_INF_MAG = 31'h7F80_0000;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // Denormals (exp == 0) are treated as zero.
  function automatic fp_class_e fp_classify(input logic [31:0] x);
    if (x[30:23] == 8'd0) begin
      return ZERO;
    end else if (x[30:23] == 8'hFF) begin
      return (x[22:0] == 23'd0) ? INF : NAN;
    end else begin
      return NORM;
    end
  endfunction

endpackage

// File: rtl/axis_float_mul_lanes_if.sv
// Generic AXI-Stream bundle: data, user, last with valid/ready handshake.
interface axis_float_mul_lanes_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] data;
  logic [USER_W-1:0] user;
  logic              last;
  logic              valid;
  logic              ready;

  modport master (output data, output user, output last, output valid, input ready);
  modport slave  (input data, input user, input last, input valid, output ready);
endinterface

// File: rtl/float_mul_lane.sv
// One lane of the float multiplier: S1 unpack/classify, S2 mantissa product
// and exponent sum, S3 normalise/round/pack. All stages advance on en.
module float_mul_lane
  import float_pkg::*;
#(
  parameter bit RNE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        ovf,
  output logic        udf
);

  localparam logic signed [9:0] E_MAX = 10'(FP_EXP_MAX);

  fp_class_e          ca, cb;
  logic               sign, spec;
  logic [31:0]        spec_val;

  logic               s1_sign, s1_spec;
  logic [31:0]        s1_spec_val;
  logic signed [9:0]  s1_exp;
  logic [23:0]        s1_ma, s1_mb;

  logic               s2_sign, s2_spec;
  logic [31:0]        s2_spec_val;
  logic signed [9:0]  s2_exp;
  logic [47:0]        s2_p;

  logic [22:0]        mant, mant_r;
  logic               guard, sticky, rup, carry;
  logic signed [9:0]  e_n;
  logic [31:0]        res_n;
  logic               ovf_n, udf_n;

  // Classify operands and resolve special-value results ahead of the product.
  always_comb begin
    ca       = fp_classify(a);
    cb       = fp_classify(b);
    sign     = a[31] ^ b[31];
    spec     = 1'b1;
    spec_val = FP_QNAN;
    if (ca == NAN || cb == NAN || (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
      spec_val = FP_QNAN;
    end else if (ca == INF || cb == INF) begin
      spec_val = {sign, FP_INF_MAG};
    end else if (ca == ZERO || cb == ZERO) begin
      spec_val = {sign, 31'd0};
    end else begin
      spec = 1'b0;
    end
  end

  // S1 and S2 registers: unpacked operands, then the raw 48-bit product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sign <= 1'b0; s1_spec <= 1'b0; s1_spec_val <= '0;
      s1_exp  <= '0;   s1_ma   <= '0;   s1_mb       <= '0;
      s2_sign <= 1'b0; s2_spec <= 1'b0; s2_spec_val <= '0;
      s2_exp  <= '0;   s2_p    <= '0;
    end else if (en) begin
      s1_sign     <= sign;
      s1_spec     <= spec;
      s1_spec_val <= spec_val;
      s1_exp      <= 10'({2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(FP_BIAS));
      s1_ma       <= {1'b1, a[22:0]};
      s1_mb       <= {1'b1, b[22:0]};
      s2_sign     <= s1_sign;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_exp      <= s1_exp;
      s2_p        <= s1_ma * s1_mb;
    end
  end

  // Normalise the product, round, and range-check the exponent.
  always_comb begin
    if (s2_p[47]) begin
      mant   = s2_p[46:24];
      guard  = s2_p[23];
      sticky = |s2_p[22:0];
      e_n    = s2_exp + 10'sd1;
    end else begin
      mant   = s2_p[45:23];
      guard  = s2_p[22];
      sticky = |s2_p[21:0];
      e_n    = s2_exp;
    end
    rup             = RNE & guard & (sticky | mant[0]);
    {carry, mant_r} = {1'b0, mant} + 24'(rup);
    if (carry) e_n = e_n + 10'sd1;
    ovf_n = 1'b0;
    udf_n = 1'b0;
    if (s2_spec) begin
      res_n = s2_spec_val;
    end else if (e_n >= E_MAX) begin
      res_n = {s2_sign, FP_INF_MAG};
      ovf_n = 1'b1;
    end else if (e_n <= 10'sd0) begin
      res_n = {s2_sign, 31'd0};
      udf_n = 1'b1;
    end else begin
      res_n = {s2_sign, e_n[7:0], mant_r};
    end
  end

  // S3 output register; holds while the stream is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (en) begin
      result <= res_n;
      ovf    <= ovf_n;
      udf    <= udf_n;
    end
  end

endmodule

// File: rtl/axis_float_mul_lanes.sv
// Multi-lane AXIS float multiplier: LANES float_mul_lane datapaths sharing
// one valid/user/last shift chain and a single advance enable.
//
// Handshake: a beat transfers on a port when valid & ready are both high at
// the clock edge. The pipeline advances only when the output register is
// empty or being drained (adv); s_axis.ready equals adv outside reset, so a
// stalled output back-pressures the producer and all stages hold.
module axis_float_mul_lanes
  import float_pkg::*;
#(
  parameter int    LANES      = 2,
  parameter int    USER_W     = 1,
  parameter string ROUND_MODE = "RNE"
) (
  input  logic clk,
  input  logic rst_n,
  axis_float_mul_lanes_if.slave  s_axis,
  axis_float_mul_lanes_if.master m_axis
);

  localparam bit RNE = (ROUND_MODE == "RNE");

  logic                  adv;
  logic [2:0]            vld;
  logic [2:0]            last_q;
  logic [USER_W-1:0]     user_q [3];
  logic [32*LANES-1:0]   prod;
  logic [2*LANES-1:0]    flags;

  assign adv          = ~vld[2] | m_axis.ready;
  assign s_axis.ready = rst_n & adv;

  // Valid/last/user shift chain, in lockstep with the lane stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld    <= '0;
      last_q <= '0;
      for (int i = 0; i < 3; i++) user_q[i] <= '0;
    end else if (adv) begin
      vld       <= {vld[1:0], s_axis.valid};
      last_q    <= {last_q[1:0], s_axis.last};
      user_q[0] <= s_axis.user;
      user_q[1] <= user_q[0];
      user_q[2] <= user_q[1];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    float_mul_lane #(.RNE(RNE)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (adv),
      .a      (s_axis.data[64*i+32 +: 32]),
      .b      (s_axis.data[64*i +: 32]),
      .result (prod[32*i +: 32]),
      .ovf    (flags[2*i+1]),
      .udf    (flags[2*i])
    );
  end

  assign m_axis.data  = prod;
  assign m_axis.user  = {user_q[2], flags};
  assign m_axis.last  = last_q[2];
  assign m_axis.valid = vld[2];

endmodule

// File: tb/tb_axis_float_mul_lanes.sv
// Bench for axis_float_mul_lanes: a 4-lane RNE instance plus a 1-lane TRUNC
// instance fed with lane 0 of the same stream, checked against a float model.
module tb_axis_float_mul_lanes;
  localparam int LANES  = 4;
  localparam int USER_W = 3;
  localparam int EXP_W  = 1 + 2 + 32 + 1 + USER_W + 2*LANES + 32*LANES;

  typedef struct packed {
    logic [64*LANES-1:0] data;
    logic [USER_W-1:0]   user;
    logic                last;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_float_mul_lanes_if #(.DATA_W(64*LANES), .USER_W(USER_W))         s_axis ();
  axis_float_mul_lanes_if #(.DATA_W(32*LANES), .USER_W(USER_W+2*LANES)) m_axis ();
  axis_float_mul_lanes_if #(.DATA_W(64),       .USER_W(USER_W))         st_axis ();
  axis_float_mul_lanes_if #(.DATA_W(32),       .USER_W(USER_W+2))       mt_axis ();

  assign st_axis.data  = s_axis.data[63:0];
  assign st_axis.user  = s_axis.user;
  assign st_axis.last  = s_axis.last;
  assign st_axis.valid = s_axis.valid;
  assign mt_axis.ready = m_axis.ready;

  axis_float_mul_lanes #(.LANES(LANES), .USER_W(USER_W), .ROUND_MODE("RNE")) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_axis), .m_axis(m_axis));
  axis_float_mul_lanes #(.LANES(1), .USER_W(USER_W), .ROUND_MODE("TRUNC")) dut_t (
    .clk(clk), .rst_n(rst_n), .s_axis(st_axis), .m_axis(mt_axis));

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  beat_t            src_q[$];
  bit               pending = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;

  // ---------------- reference model ----------------
  // Returns {ovf, udf, result}; exact integer product rounded by remainder.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b, input bit rne);
    logic sign;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned p, keep, rem, half;
    int e, sh;
    sign = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    a_zero = (ea == 8'd0); b_zero = (eb == 8'd0);
    a_inf = (ea == 8'hFF) && (fa == 23'd0); b_inf = (eb == 8'hFF) && (fb == 23'd0);
    a_nan = (ea == 8'hFF) && (fa != 23'd0); b_nan = (eb == 8'hFF) && (fb != 23'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {2'b00, 32'h7FC00000};
    if (a_inf || b_inf) return {2'b00, sign, 31'h7F800000};
    if (a_zero || b_zero) return {2'b00, sign, 31'h0};
    p = 64'({1'b1, fa}) * 64'({1'b1, fb});
    e = int'(ea) + int'(eb) - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
    else sh = 23;
    keep = p >> sh;
    rem  = p - (keep << sh);
    half = 64'd1 << (sh - 1);
    if (rne && (rem > half || (rem == half && keep[0]))) keep = keep + 1;
    if (keep == (64'd1 << 24)) begin keep = keep >> 1; e = e + 1; end
    if (e >= 255) return {2'b10, sign, 31'h7F800000};
    if (e <= 0) return {2'b01, sign, 31'h0};
    return {2'b00, sign, e[7:0], keep[22:0]};
  endfunction

  // Expected word: {trunc valid, trunc flags, trunc data, last, user, flags, data}.
  function automatic logic [EXP_W-1:0] model_beat(input beat_t bt);
    logic [32*LANES-1:0] d;
    logic [2*LANES-1:0]  f;
    logic [33:0]         r, t;
    for (int i = 0; i < LANES; i++) begin
      r = fmul(bt.data[64*i+32 +: 32], bt.data[64*i +: 32], 1'b1);
      d[32*i +: 32] = r[31:0];
      f[2*i +: 2]   = r[33:32];
    end
    t = fmul(bt.data[63:32], bt.data[31:0], 1'b0);
    return {1'b1, t[33:32], t[31:0], bt.last, bt.user, f, d};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       e = 8'hFF;
      3:       e = 8'($urandom_range(200, 254));
      4:       e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    for (int i = 0; i < LANES; i++) bt.data[64*i +: 64] = {rand_op(), rand_op()};
    bt.user = USER_W'($urandom);
    bt.last = 1'($urandom);
    return bt;
  endfunction

  // ---------------- driver ----------------
  // One clock: present the head of src_q (held until accepted), set m_ready,
  // then report whether input/output handshakes happen at the next edge.
  task automatic cycle(input int pv, input int pr, output bit acc, output bit fire,
                       output logic [EXP_W-1:0] got);
    @(posedge clk); #1;
    if (!pending && src_q.size() > 0 && $urandom_range(0, 99) < pv) begin
      s_axis.data  = src_q[0].data;
      s_axis.user  = src_q[0].user;
      s_axis.last  = src_q[0].last;
      s_axis.valid = 1'b1;
      pending = 1'b1;
    end else if (!pending) begin
      s_axis.valid = 1'b0;
    end
    m_axis.ready = ($urandom_range(0, 99) < pr);
    #1;
    acc  = s_axis.valid && s_axis.ready;
    fire = m_axis.valid && m_axis.ready;
    got  = {mt_axis.valid, mt_axis.user[1:0], mt_axis.data, m_axis.last, m_axis.user, m_axis.data};
    if (acc) begin
      exp_q.push_back(model_beat(src_q[0]));
      void'(src_q.pop_front());
      pending = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    s_axis.valid = 1'b0; s_axis.data = '0; s_axis.user = '0; s_axis.last = 1'b0;
    m_axis.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (m_axis.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", m_axis.valid); end
    n_vec++; if (m_axis.data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", m_axis.data); end
    n_vec++; if (m_axis.user !== '0) begin n_err++; $display("FAIL reset_user: got %h want 0", m_axis.user); end
    n_vec++; if (m_axis.last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", m_axis.last); end
    n_vec++; if (s_axis.ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", s_axis.ready); end
    n_vec++; if (mt_axis.valid !== 1'b0) begin n_err++; $display("FAIL reset_trunc_valid: got %b want 0", mt_axis.valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (s_axis.ready !== 1'b1) begin n_err++; $display("FAIL release_s_ready: got %b want 1", s_axis.ready); end
  endtask

  task automatic test_latency();
    bit acc, fire, seen;
    logic [EXP_W-1:0] got, ew;
    beat_t bt;
    int acc_i;
    bt = rand_beat();
    bt.data[63:0] = {32'h3FC00000, 32'h40000000};
    src_q.push_back(bt);
    acc_i = -100; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(100, 100, acc, fire, got);
      if (acc) acc_i = i;
      if (fire) begin
        seen = 1'b1;
        ew = exp_q.pop_front();
        n_vec++; if (i != acc_i + 3) begin n_err++; $display("FAIL latency: got %0d cycles want 3", i - acc_i); end
        n_vec++; if (m_axis.data[31:0] !== 32'h40400000) begin n_err++; $display("FAIL mul_1p5x2: got %h want 40400000", m_axis.data[31:0]); end
        n_vec++; if (got !== ew) begin n_err++; $display("FAIL latency_beat: got %h want %h", got, ew); end
      end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL latency_timeout: got no output want 1 beat"); end
  endtask

  task automatic test_directed();
    logic [31:0] a_tab [7] = '{32'h3FC00000, 32'h7F000000, 32'h00800000, 32'h7F800000,
                               32'hFF800000, 32'h00000001, 32'h3F800001};
    logic [31:0] b_tab [7] = '{32'h40000000, 32'h7F000000, 32'h00800000, 32'h00000000,
                               32'h40000000, 32'h40000000, 32'h3FC00000};
    logic [31:0] r_tab [7] = '{32'h40400000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                               32'hFF800000, 32'h00000000, 32'h3FC00002};
    logic [31:0] t_tab [7] = '{32'h40400000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                               32'hFF800000, 32'h00000000, 32'h3FC00001};
    logic [1:0]  f_tab [7] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    bit acc, fire;
    logic [EXP_W-1:0] got, ew;
    beat_t bt;
    int k;
    for (int j = 0; j < 7; j++) begin
      for (int i = 0; i < LANES; i++) bt.data[64*i +: 64] = {a_tab[j], b_tab[j]};
      bt.user = USER_W'(j);
      bt.last = (j == 6);
      src_q.push_back(bt);
    end
    k = 0;
    for (int c = 0; c < 60 && k < 7; c++) begin
      cycle(100, 100, acc, fire, got);
      if (fire) begin
        ew = exp_q.pop_front();
        n_vec++; if (got !== ew) begin n_err++; $display("FAIL directed_beat%0d: got %h want %h", k, got, ew); end
        n_vec++; if (m_axis.data[31:0] !== r_tab[k]) begin n_err++; $display("FAIL directed_rne%0d: got %h want %h", k, m_axis.data[31:0], r_tab[k]); end
        n_vec++; if (m_axis.user[1:0] !== f_tab[k]) begin n_err++; $display("FAIL directed_flags%0d: got %b want %b", k, m_axis.user[1:0], f_tab[k]); end
        n_vec++; if (mt_axis.data !== t_tab[k]) begin n_err++; $display("FAIL directed_trunc%0d: got %h want %h", k, mt_axis.data, t_tab[k]); end
        k++;
      end
    end
    n_vec++; if (k != 7) begin n_err++; $display("FAIL directed_timeout: got %0d beats want 7", k); end
  endtask

  task automatic test_packet_stall();
    bit acc, fire;
    logic [EXP_W-1:0] got, ew;
    beat_t bt;
    int out_n, pr;
    for (int j = 0; j < 8; j++) begin
      bt = rand_beat();
      bt.last = (j == 7);
      src_q.push_back(bt);
    end
    out_n = 0;
    for (int c = 1; c <= 80 && out_n < 8; c++) begin
      pr = (c >= 4 && c <= 8) ? 0 : 100;
      cycle(100, pr, acc, fire, got);
      if (m_axis.valid && !m_axis.ready && exp_q.size() > 0) begin
        n_vec++; if (got !== exp_q[0]) begin n_err++; $display("FAIL stall_hold: got %h want %h", got, exp_q[0]); end
        if (s_axis.valid) begin
          n_vec++; if (s_axis.ready !== 1'b0) begin n_err++; $display("FAIL stall_s_ready: got %b want 0", s_axis.ready); end
        end
      end
      if (fire) begin
        ew = exp_q.pop_front();
        n_vec++; if (got !== ew) begin n_err++; $display("FAIL packet_beat%0d: got %h want %h", out_n, got, ew); end
        out_n++;
      end
    end
    n_vec++; if (out_n != 8) begin n_err++; $display("FAIL packet_timeout: got %0d beats want 8", out_n); end
  endtask

  task automatic test_back_to_back();
    bit acc, fire;
    logic [EXP_W-1:0] got, ew;
    int n_both, c;
    for (int j = 0; j < 20; j++) src_q.push_back(rand_beat());
    n_both = 0;
    for (c = 0; c < 200 && (src_q.size() > 0 || exp_q.size() > 0 || pending); c++) begin
      cycle(100, 100, acc, fire, got);
      if (acc && fire) n_both++;
      if (fire) begin
        ew = exp_q.pop_front();
        n_vec++; if (got !== ew) begin n_err++; $display("FAIL full_rate_beat: got %h want %h", got, ew); end
      end
    end
    n_vec++; if (n_both != 17) begin n_err++; $display("FAIL full_rate_overlap: got %0d want 17", n_both); end
    n_vec++; if (c != 23) begin n_err++; $display("FAIL full_rate_cycles: got %0d want 23", c); end
    for (int j = 0; j < 150; j++) src_q.push_back(rand_beat());
    for (c = 0; c < 3000 && (src_q.size() > 0 || exp_q.size() > 0 || pending); c++) begin
      cycle(70, 60, acc, fire, got);
      if (fire) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL random_extra: got %h want none", got);
        end else begin
          ew = exp_q.pop_front();
          n_vec++; if (got !== ew) begin n_err++; $display("FAIL random_beat: got %h want %h", got, ew); end
        end
      end
    end
    n_vec++; if (exp_q.size() != 0 || src_q.size() != 0) begin n_err++; $display("FAIL random_timeout: got %0d left want 0", exp_q.size() + src_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit acc, fire;
    logic [EXP_W-1:0] got;
    for (int j = 0; j < 3; j++) src_q.push_back(rand_beat());
    for (int j = 0; j < 3; j++) cycle(100, 0, acc, fire, got);
    @(posedge clk); #1;
    rst_n = 1'b0; s_axis.valid = 1'b0; m_axis.ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; m_axis.ready = 1'b1;
    #1;
    n_vec++; if (m_axis.valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", m_axis.valid); end
    n_vec++; if (m_axis.data !== '0) begin n_err++; $display("FAIL midreset_data: got %h want 0", m_axis.data); end
    exp_q.delete();
    pending = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #2;
      n_vec++; if (m_axis.valid !== 1'b0 || mt_axis.valid !== 1'b0) begin
        n_err++; $display("FAIL stale_beat%0d: got %b%b want 00", j, m_axis.valid, mt_axis.valid);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_packet_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
